aes_input_loader: RTL and testbench
===================================

# aes_input_loader

Byte-serial front end for the AES-128 `decryption` block. It assembles an incoming byte stream into the 128-bit `key` and 128-bit `inputData` words, then raises `inputsLoadedFlag` and holds both words stable until `decryption` reports completion on `dataDecryptedFlag`. It then re-arms for the next block. It sits directly upstream of `decryption`, between the byte source (UART receiver or host interface) and the cipher core.

## Interface
- `KEY_REUSE`, default 0: 0 = every block loads 16 key bytes then 16 data bytes; 1 = key is loaded only for the first block after reset, and later blocks load 16 data bytes only.
- `IDLE_TIMEOUT`, default 1000000: number of consecutive cycles without an accepted byte, in a partially loaded phase, before the partial load is discarded. 0 disables the timeout. Counter width is clog2(`IDLE_TIMEOUT`+1).
- `clock` in 1: 50 MHz system clock; all logic on rising edge.
- `resetModule` in 1: one clock; reset is synchronous and active-low.
- `byteIn` in 8: incoming byte.
- `byteValid` in 1: `byteIn` is valid this cycle.
- `byteReady` out 1: loader accepts a byte this cycle.
- `dataDecryptedFlag` in 1: completion flag from `decryption`.
- `key` out 128: assembled key to `decryption`.
- `inputData` out 128: assembled ciphertext to `decryption`.
- `inputsLoadedFlag` out 1: both words are complete and stable.

## Operation
- **Byte order:** first byte received is the MSB. Key bytes fill `key[127:120]` down to `key[7:0]`; data bytes fill `inputData` the same way. Implement as a left shift of 8 bits per accepted byte.
- **Accept rule:** a byte is accepted on a rising edge where `byteValid` = 1 and `byteReady` = 1. A 4-bit byte counter increments per accepted byte and wraps from 15 to 0 at the end of each phase.
- **State LOAD_KEY:** `byteReady` = 1. Bytes shift into `key`. On the 16th accepted byte, go to LOAD_DATA and set the internal `keyValid` bit.
- **State LOAD_DATA:** `byteReady` = 1. Bytes shift into `inputData`. On the 16th accepted byte, go to LOADED.
- **State LOADED:** `inputsLoadedFlag` = 1 and `byteReady` = 0. `key` and `inputData` are frozen. When `dataDecryptedFlag` = 1, go to RELEASE.
- **State RELEASE:** `inputsLoadedFlag` = 0 and `byteReady` = 0. When `dataDecryptedFlag` = 0, go to LOAD_KEY, or to LOAD_DATA if `KEY_REUSE` = 1 and `keyValid` = 1.
- **Return to loading:** `key` and `inputData` keep their old values until overwritten by shifting.
- **Timeout:**
  - Applies only in LOAD_KEY or LOAD_DATA with byte counter ≠ 0.
  - The idle counter clears on every accepted byte and counts otherwise.
  - On reaching `IDLE_TIMEOUT`: byte counter goes to 0 and the current phase restarts. A key phase stays in LOAD_KEY. A data phase stays in LOAD_DATA; the key is retained and `keyValid` is unchanged.
  - The idle counter is held at 0 in LOADED and RELEASE, and while the byte counter = 0.
- **Input gating:** `byteValid` while `byteReady` = 0 is ignored; no byte is consumed.

## Timing
- **Reset** (`resetModule` = 0 at a rising edge) sets:
  - state = LOAD_KEY
  - `key` = 0, `inputData` = 0, `inputsLoadedFlag` = 0
  - byte counter = 0, idle counter = 0, `keyValid` = 0
- **`byteReady` during reset:** forced to 0 combinationally while `resetModule` = 0. It is 1 from the first cycle after reset is released.
- **`byteReady` otherwise:** derived from the registered state only. There is no combinational path from `byteValid`.
- **Load latency:** `inputsLoadedFlag` rises in the cycle after the edge that accepts the 32nd byte (16th byte when reusing the key). Minimum is 32 cycles from the first byte.
- **Release latency:** `inputsLoadedFlag` falls in the cycle after the edge that samples `dataDecryptedFlag` = 1. `byteReady` rises in the cycle after the edge that samples `dataDecryptedFlag` = 0 in RELEASE.
- **Reset mid-load or while LOADED:** the partial or complete block is discarded, `inputsLoadedFlag` drops at that edge, and a full key is required again.
- **Timeout and byte on the same edge:** the accepted byte wins; the byte counter increments and the idle counter clears.
- **Flag already high on entry:** if `dataDecryptedFlag` is still high on entry to LOADED, go to RELEASE on the next edge.

## Test plan
- **Nominal block:** reset, then send the 16 key bytes `13 11 1d 7f e3 94 4a 17 f3 07 a7 8b 4d 2b 30 c5`, then the 16 ciphertext bytes `69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a`, one per cycle.
  - Required: `key` = 13111d7fe3944a17f307a78b4d2b30c5 and `inputData` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `inputsLoadedFlag` rises exactly 1 cycle after the last byte and `byteReady` = 0.
  - With `decryption` attached, `outputData` = 00112233445566778899aabbccddeeff.
- **Back-pressure:** while LOADED, hold `byteValid` = 1 with `byteIn` = AA for 100 cycles -> `inputData` and `key` are unchanged and no byte is consumed.
- **Handshake release:**
  - Pulse `dataDecryptedFlag` high for 3 cycles -> `inputsLoadedFlag` falls 1 cycle after the first high sample.
  - `byteReady` rises 1 cycle after `dataDecryptedFlag` returns low.
- **Key reuse:** with `KEY_REUSE` = 1, a second block loads after only 16 data bytes (`00 11 … ff`) -> `key` is still 13111d7f…30c5 and `inputData` = 00112233445566778899aabbccddeeff.
- **Timeout:** with `IDLE_TIMEOUT` = 10, send 5 data bytes, then go idle for 10 cycles, then send 16 fresh bytes -> `inputData` equals the 16 fresh bytes only. A gap of 9 cycles does not discard the partial load.
- **Reset mid-load:** pull `resetModule` low for 1 cycle after 20 bytes -> all outputs are 0 at the next edge, and the next 32 bytes load correctly.

Source files
------------

// File: rtl/aes_input_loader.sv
// rtl/aes_input_loader.sv - byte-serial key/ciphertext loader feeding the AES-128 decryption core
//
// Purpose:
//   Shifts an incoming byte stream (MSB first) into a 128-bit key and a
//   128-bit ciphertext word.  Once both are complete it raises
//   inputsLoadedFlag and freezes them until the cipher core pulses
//   dataDecryptedFlag.  Then it re-arms for the next block.  Optional key
//   reuse skips the key phase after the first block.  An optional idle
//   timeout discards a partially loaded phase.
//
// Ports:
//   clock             in   system clock, rising edge
//   resetModule       in   synchronous active-low reset
//   byteIn[7:0]       in   incoming byte
//   byteValid         in   byteIn valid this cycle
//   byteReady         out  loader accepts a byte this cycle
//   dataDecryptedFlag in   completion flag from the decryption core
//   key[127:0]        out  assembled key
//   inputData[127:0]  out  assembled ciphertext
//   inputsLoadedFlag  out  key and inputData complete and stable

module aes_input_loader #(
  parameter int KEY_REUSE    = 0,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [7:0]   byteIn,
  input  logic         byteValid,
  output logic         byteReady,
  input  logic         dataDecryptedFlag,
  output logic [127:0] key,
  output logic [127:0] inputData,
  output logic         inputsLoadedFlag
);

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (IDLE_TIMEOUT > 0);
  localparam logic [IW-1:0] IDLE_LAST = TIMEOUT_EN ? IW'(IDLE_TIMEOUT - 1) : '0;
  localparam bit REUSE_EN = (KEY_REUSE != 0);

  typedef enum logic [1:0] {
    S_LOAD_KEY  = 2'd0,
    S_LOAD_DATA = 2'd1,
    S_LOADED    = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [3:0]      r_byte_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_key_valid;
  logic [127:0]    r_key;
  logic [127:0]    r_data;

  logic            w_loading;
  logic            w_loaded;
  logic            w_accept;
  logic            w_last_byte;
  logic            w_timeout;

  // State register.
  always_ff @(posedge clock) begin
    if (!resetModule) begin
      r_state <= S_LOAD_KEY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    w_loading    = 1'b0;
    w_loaded     = 1'b0;
    case (r_state)
      S_LOAD_KEY: begin
        w_loading = 1'b1;
        if (w_last_byte) begin
          w_next_state = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        w_loading = 1'b1;
        if (w_last_byte) begin
          w_next_state = S_LOADED;
        end
      end
      S_LOADED: begin
        w_loaded = 1'b1;
        if (dataDecryptedFlag) begin
          w_next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!dataDecryptedFlag) begin
          w_next_state = (REUSE_EN && r_key_valid) ? S_LOAD_DATA : S_LOAD_KEY;
        end
      end
      default: begin
        w_next_state = S_LOAD_KEY;
      end
    endcase
  end

  // byteReady depends only on registered state, masked while reset is held.
  assign byteReady   = w_loading & resetModule;
  assign w_accept    = byteValid & byteReady;
  assign w_last_byte = w_accept & (r_byte_cnt == 4'd15);

  // Fires only on an idle cycle; an accepted byte on the same edge wins.
  assign w_timeout = TIMEOUT_EN && w_loading && (r_byte_cnt != 4'd0) &&
                     !w_accept && (r_idle_cnt == IDLE_LAST);

  // Datapath: shift registers, byte counter, idle counter, key-valid bit.
  always_ff @(posedge clock) begin
    if (!resetModule) begin
      r_key       <= '0;
      r_data      <= '0;
      r_byte_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_key_valid <= 1'b0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 4'd1;
      r_idle_cnt <= '0;
      if (r_state == S_LOAD_KEY) begin
        r_key <= {r_key[119:0], byteIn};
        if (r_byte_cnt == 4'd15) begin
          r_key_valid <= 1'b1;
        end
      end else begin
        r_data <= {r_data[119:0], byteIn};
      end
    end else if (!w_loading || (r_byte_cnt == 4'd0)) begin
      r_idle_cnt <= '0;
    end else if (w_timeout) begin
      // Restart the current phase; shifted bytes are simply overwritten later.
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (TIMEOUT_EN) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign key              = r_key;
  assign inputData        = r_data;
  assign inputsLoadedFlag = w_loaded;

endmodule

// File: tb/tb_aes_input_loader.sv
// tb/tb_aes_input_loader.sv - directed self-checking bench for aes_input_loader

module tb_aes_input_loader;

  localparam logic [127:0] KEY_NOM  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] DATA_NOM = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] DATA_2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DATA_A   = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] DATA_B   = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
  localparam logic [127:0] DATA_C   = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;

  logic         clock;
  logic         resetModule;
  logic [7:0]   byteIn;
  logic         byteValid;
  logic         byteReady;
  logic         dataDecryptedFlag;
  logic [127:0] key;
  logic [127:0] inputData;
  logic         inputsLoadedFlag;

  int vectors;
  int miscompares;

  aes_input_loader #(
    .KEY_REUSE   (1),
    .IDLE_TIMEOUT(10)
  ) u_dut (
    .clock            (clock),
    .resetModule      (resetModule),
    .byteIn           (byteIn),
    .byteValid        (byteValid),
    .byteReady        (byteReady),
    .dataDecryptedFlag(dataDecryptedFlag),
    .key              (key),
    .inputData        (inputData),
    .inputsLoadedFlag (inputsLoadedFlag)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends the first n bytes of v, MSB first, one per cycle.
  task automatic send_bytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      byteIn    = v[127-8*i -: 8];
      byteValid = 1'b1;
      step();
    end
    byteValid = 1'b0;
  endtask

  task automatic release_block();
    dataDecryptedFlag = 1'b1;
    step();
    dataDecryptedFlag = 1'b0;
    step();
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    resetModule       = 1'b0;
    byteIn            = 8'h00;
    byteValid         = 1'b0;
    dataDecryptedFlag = 1'b0;

    // Reset state
    step();
    check("rst_ready",  {127'b0, byteReady}, 128'd0);
    check("rst_key",    key, 128'd0);
    check("rst_data",   inputData, 128'd0);
    check("rst_loaded", {127'b0, inputsLoadedFlag}, 128'd0);
    resetModule = 1'b1;
    step();
    check("ready_after_rst", {127'b0, byteReady}, 128'd1);

    // Reset mid-load after 20 bytes
    send_bytes(KEY_NOM, 16);
    send_bytes(DATA_NOM, 4);
    resetModule = 1'b0;
    step();
    check("midrst_key",    key, 128'd0);
    check("midrst_data",   inputData, 128'd0);
    check("midrst_loaded", {127'b0, inputsLoadedFlag}, 128'd0);
    check("midrst_ready",  {127'b0, byteReady}, 128'd0);
    resetModule = 1'b1;
    step();

    // Nominal block: full key then data
    send_bytes(KEY_NOM, 16);
    check("key_only_loaded", {127'b0, inputsLoadedFlag}, 128'd0);
    send_bytes(DATA_NOM, 15);
    check("pre_last_loaded", {127'b0, inputsLoadedFlag}, 128'd0);
    check("pre_last_ready",  {127'b0, byteReady}, 128'd1);
    send_bytes(DATA_NOM << 120, 1);
    check("nom_loaded", {127'b0, inputsLoadedFlag}, 128'd1);
    check("nom_ready",  {127'b0, byteReady}, 128'd0);
    check("nom_key",    key, KEY_NOM);
    check("nom_data",   inputData, DATA_NOM);

    // Back-pressure while LOADED
    byteIn    = 8'hAA;
    byteValid = 1'b1;
    repeat (100) step();
    byteValid = 1'b0;
    check("bp_key",    key, KEY_NOM);
    check("bp_data",   inputData, DATA_NOM);
    check("bp_loaded", {127'b0, inputsLoadedFlag}, 128'd1);

    // Handshake release: flag high for 3 cycles
    dataDecryptedFlag = 1'b1;
    step();
    check("rel_loaded_fall", {127'b0, inputsLoadedFlag}, 128'd0);
    check("rel_ready_low1",  {127'b0, byteReady}, 128'd0);
    step();
    step();
    check("rel_ready_low3",  {127'b0, byteReady}, 128'd0);
    dataDecryptedFlag = 1'b0;
    step();
    check("rel_ready_rise",  {127'b0, byteReady}, 128'd1);
    check("rel_key_kept",    key, KEY_NOM);

    // Key reuse: 16 data bytes only
    send_bytes(DATA_2, 16);
    check("reuse_loaded", {127'b0, inputsLoadedFlag}, 128'd1);
    check("reuse_key",    key, KEY_NOM);
    check("reuse_data",   inputData, DATA_2);
    release_block();

    // Gap of 9 idle cycles keeps the partial load
    send_bytes(DATA_A, 5);
    repeat (9) step();
    send_bytes(DATA_A << 40, 11);
    check("gap9_loaded", {127'b0, inputsLoadedFlag}, 128'd1);
    check("gap9_data",   inputData, DATA_A);
    release_block();

    // Gap of 10 idle cycles discards the partial load
    send_bytes(DATA_B, 5);
    repeat (10) step();
    send_bytes(DATA_C, 15);
    check("to_not_loaded", {127'b0, inputsLoadedFlag}, 128'd0);
    check("to_ready",      {127'b0, byteReady}, 128'd1);
    send_bytes(DATA_C << 120, 1);
    check("to_loaded", {127'b0, inputsLoadedFlag}, 128'd1);
    check("to_data",   inputData, DATA_C);
    check("to_key",    key, KEY_NOM);

    // Flag already high on entry to LOADED is consumed immediately
    release_block();
    dataDecryptedFlag = 1'b1;
    send_bytes(DATA_2, 16);
    check("early_flag_loaded", {127'b0, inputsLoadedFlag}, 128'd1);
    step();
    check("early_flag_release", {127'b0, inputsLoadedFlag}, 128'd0);
    dataDecryptedFlag = 1'b0;
    step();
    check("early_flag_ready", {127'b0, byteReady}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
